// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: converts single-beat local commands into AXI4-Lite
// read/write transactions, one outstanding, and returns one response each.
module axi_lite_master #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RSP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                bready_q, bready_d;
  logic                rready_q, rready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;

  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs, aw_ok, w_ok;

  assign cmd_ready = (state_q == IDLE) && !areset;
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign aw_hs     = awvalid_q && m_axi_awready;
  assign w_hs      = wvalid_q && m_axi_wready;
  assign b_hs      = bready_q && m_axi_bvalid;
  assign ar_hs     = arvalid_q && m_axi_arready;
  assign r_hs      = rready_q && m_axi_rvalid;
  assign rsp_hs    = rsp_valid_q && rsp_ready;
  // A write channel counts as finished if it completed earlier or completes now
  assign aw_ok     = aw_done_q || aw_hs;
  assign w_ok      = w_done_q || w_hs;

  // State and registered outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_hs) state_d = cmd_write ? WRITE : READ;
      WRITE:   if (aw_ok && w_ok) state_d = WRESP;
      WRESP:   if (b_hs) state_d = RSP;
      READ:    if (ar_hs) state_d = RDATA;
      RDATA:   if (r_hs) state_d = RSP;
      RSP:     if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          awvalid_d = cmd_write;
          wvalid_d  = cmd_write;
          arvalid_d = !cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WRITE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_ok && w_ok) bready_d = 1'b1;
      end
      WRESP: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_resp_d  = m_axi_bresp;
        end
      end
      READ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RDATA: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
        end
      end
      RSP: begin
        if (rsp_hs) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awprot  = PROT;
  assign m_axi_arprot  = PROT;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_rready  = rready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: memory-backed AXI4-Lite responder with random
// stalls, plus a command-level reference model predicting every response.
module tb_axi_lite_master;
  localparam int unsigned ADDR_W = 32;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wstrb;
  logic              rsp_valid, rsp_ready, rsp_write;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]        m_axi_awprot, m_axi_arprot;
  logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0]       m_axi_wdata, m_axi_rdata;
  logic [3:0]        m_axi_wstrb;
  logic [1:0]        m_axi_bresp, m_axi_rresp;
  logic              m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic              m_axi_rvalid, m_axi_rready;

  axi_lite_master #(.ADDR_W(ADDR_W), .PROT(3'b000)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Target address map: addr[6] set gives an error (addr[2] picks DECERR vs SLVERR)
  function automatic logic [1:0] resp_of(input logic [31:0] a);
    if (!a[6]) return 2'b00;
    return a[2] ? 2'b11 : 2'b10;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  logic [31:0] smem [16];
  logic [31:0] ref_mem [16];
  bit          got_aw, got_w, got_ar;
  logic [31:0] s_awaddr, s_araddr, s_wdata;
  logic [3:0]  s_wstrb;
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait, wait_max;
  int          b_hs_cnt, r_hs_cnt;
  bit          force_r;
  logic [31:0] force_rdata;
  logic [1:0]  force_rresp;
  bit          p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
  logic [31:0] p_awaddr, p_araddr, p_wdata;
  logic [3:0]  p_wstrb;

  // Responder: handshakes of the previous edge are recovered from last-negedge samples
  always @(negedge aclk) begin
    if (areset) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_rvalid = 0;
      got_aw = 0; got_w = 0; got_ar = 0;
      {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
    end else begin
      if (p_awv && p_awr) begin
        got_aw = 1; s_awaddr = p_awaddr; aw_wait = $urandom_range(0, wait_max);
        check_eq("aw_drop", 64'(m_axi_awvalid), 64'd0);
      end else if (p_awv)
        check_eq("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, p_awaddr});
      if (p_wv && p_wr) begin
        got_w = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; w_wait = $urandom_range(0, wait_max);
        check_eq("w_drop", 64'(m_axi_wvalid), 64'd0);
      end else if (p_wv)
        check_eq("w_hold", {m_axi_wvalid, m_axi_wstrb, m_axi_wdata}, {1'b1, p_wstrb, p_wdata});
      if (p_arv && p_arr) begin
        got_ar = 1; s_araddr = p_araddr; ar_wait = $urandom_range(0, wait_max);
        check_eq("ar_drop", 64'(m_axi_arvalid), 64'd0);
      end else if (p_arv)
        check_eq("ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, p_araddr});
      if (p_bv && p_br) begin
        m_axi_bvalid = 0; got_aw = 0; got_w = 0; b_hs_cnt++; b_wait = $urandom_range(0, wait_max);
      end
      if (p_rv && p_rr) begin
        m_axi_rvalid = 0; got_ar = 0; r_hs_cnt++; r_wait = $urandom_range(0, wait_max);
      end
      m_axi_awready = 0;
      if (m_axi_awvalid && !got_aw) begin
        if (aw_wait > 0) aw_wait--; else m_axi_awready = 1;
      end
      m_axi_wready = 0;
      if (m_axi_wvalid && !got_w) begin
        if (w_wait > 0) w_wait--; else m_axi_wready = 1;
      end
      m_axi_arready = 0;
      if (m_axi_arvalid && !got_ar) begin
        if (ar_wait > 0) ar_wait--; else m_axi_arready = 1;
      end
      if (got_aw && got_w && !m_axi_bvalid) begin
        if (b_wait > 0) b_wait--;
        else begin
          m_axi_bresp = resp_of(s_awaddr);
          if (m_axi_bresp == 2'b00) smem[s_awaddr[5:2]] = merge(smem[s_awaddr[5:2]], s_wdata, s_wstrb);
          m_axi_bvalid = 1;
        end
      end
      if (got_ar && !m_axi_rvalid) begin
        if (r_wait > 0) r_wait--;
        else begin
          if (force_r) begin
            m_axi_rdata = force_rdata; m_axi_rresp = force_rresp;
          end else begin
            m_axi_rresp = resp_of(s_araddr);
            m_axi_rdata = (m_axi_rresp == 2'b00) ? smem[s_araddr[5:2]] : (32'hBAD0_0000 | s_araddr);
          end
          m_axi_rvalid = 1;
        end
      end
      p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
      p_wv = m_axi_wvalid; p_wr = m_axi_wready; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
      p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
      p_bv = m_axi_bvalid; p_br = m_axi_bready; p_rv = m_axi_rvalid; p_rr = m_axi_rready;
    end
  end

  // One command end to end; called and returns on a negedge. exp_lat 0 skips latency check.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int hold, input bit b2b, input int exp_lat);
    int waited, cyc, bc0, rc0;
    logic [1:0]  e_resp, s_rs;
    logic [31:0] e_rdata, s_rd;
    bit          s_w;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1;
    waited = 0;
    while (!cmd_ready && waited < 50) begin @(negedge aclk); waited++; end
    if (!cmd_ready) begin
      check_eq("cmd_accept_timeout", 64'd0, 64'd1);
      cmd_valid = 0;
      return;
    end
    if (b2b) check_eq("b2b_gap", 64'(waited), 64'd0);
    e_resp = (force_r && !wr) ? force_rresp : resp_of(addr);
    if (wr) begin
      e_rdata = 32'h0;
      if (e_resp == 2'b00) ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], data, strb);
    end else if (force_r) e_rdata = force_rdata;
    else e_rdata = (e_resp == 2'b00) ? ref_mem[addr[5:2]] : (32'hBAD0_0000 | addr);
    bc0 = b_hs_cnt; rc0 = r_hs_cnt;
    @(posedge aclk); @(negedge aclk); cyc = 1;
    if (!b2b) cmd_valid = 0;
    if (wr) begin
      check_eq("aw_req", {m_axi_awvalid, m_axi_wvalid, m_axi_awprot, m_axi_awaddr}, {2'b11, 3'b000, addr});
      check_eq("w_req", {m_axi_wstrb, m_axi_wdata}, {strb, data});
    end else
      check_eq("ar_req", {m_axi_arvalid, m_axi_arprot, m_axi_araddr}, {1'b1, 3'b000, addr});
    while (!rsp_valid && cyc < 100) begin @(negedge aclk); cyc++; end
    if (!rsp_valid) begin
      check_eq("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    if (exp_lat > 0) check_eq("rsp_latency", 64'(cyc), 64'(exp_lat));
    rsp_ready = (hold == 0);
    s_rd = rsp_rdata; s_rs = rsp_resp; s_w = rsp_write;
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check_eq("hold_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, s_w, s_rs, s_rd});
      check_eq("hold_quiet", {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 64'd0);
    end
    check_eq("rsp", {rsp_write, rsp_resp, rsp_rdata}, {wr, e_resp, e_rdata});
    rsp_ready = 1;
    @(posedge aclk); @(negedge aclk);
    if (!b2b) rsp_ready = 0;
    check_eq("rsp_done", {rsp_valid, cmd_ready}, 64'b01);
    check_eq(wr ? "b_count" : "r_count", 64'(wr ? b_hs_cnt - bc0 : r_hs_cnt - rc0), 64'd1);
    check_eq("other_count", 64'(wr ? r_hs_cnt - rc0 : b_hs_cnt - bc0), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    m_axi_bresp = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0; wait_max = 0;
    b_hs_cnt = 0; r_hs_cnt = 0; force_r = 0; force_rdata = 0; force_rresp = 0;
    for (int i = 0; i < 16; i++) begin smem[i] = 32'h0; ref_mem[i] = 32'h0; end
    repeat (3) @(negedge aclk);
    check_eq("reset_ctrl", {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                            m_axi_bready, m_axi_rready, rsp_valid}, 64'd0);
    check_eq("reset_rsp", {rsp_write, rsp_resp, rsp_rdata}, 64'd0);
    check_eq("reset_bus", {m_axi_awaddr, m_axi_wstrb}, 64'd0);
    areset = 0;
    #1 check_eq("ready_after_reset", 64'(cmd_ready), 64'd1);
    @(negedge aclk);

    run_cmd(1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 3);
    run_cmd(0, 32'h4, 32'h0, 4'h0, 0, 0, 3);

    aw_wait = 3; w_wait = 0;
    run_cmd(1, 32'hC, 32'h0BAD_F00D, 4'b0101, 0, 0, 6);

    ar_wait = 2; force_r = 1; force_rdata = 32'h12345678; force_rresp = 2'b10;
    run_cmd(0, 32'h10, 32'h0, 4'h0, 0, 0, 5);
    force_r = 0;

    run_cmd(1, 32'h20, 32'h5555_1234, 4'hF, 5, 0, 3);

    run_cmd(1, 32'h8, 32'hA5A5A5A5, 4'hF, 0, 1, 3);
    run_cmd(0, 32'h8, 32'h0, 4'h0, 0, 1, 3);
    cmd_valid = 0; rsp_ready = 0;
    @(negedge aclk);

    aw_wait = 20;
    cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF; cmd_valid = 1;
    @(posedge aclk); @(negedge aclk);
    cmd_valid = 0;
    @(negedge aclk);
    check_eq("mid_aw_pending", {m_axi_awvalid, m_axi_awready}, 64'b10);
    #2 areset = 1;
    #1 check_eq("mid_reset", {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                              m_axi_bready, m_axi_rready, rsp_valid}, 64'd0);
    check_eq("mid_reset_bus", {m_axi_awaddr, m_axi_wstrb}, 64'd0);
    @(negedge aclk); @(negedge aclk);
    areset = 0; aw_wait = 0; w_wait = 0;
    #1 check_eq("ready_after_mid_reset", 64'(cmd_ready), 64'd1);
    @(negedge aclk);
    run_cmd(0, 32'h30, 32'h0, 4'h0, 0, 0, 3);

    wait_max = 3;
    for (int n = 0; n < 40; n++) begin
      a = {25'd0, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 2'b00};
      run_cmd(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 2), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite initiator that turns single-beat commands from a local requester into AXI4-Lite read or write transactions and returns one response per command. It is the other end of the 4-register AXI4-Lite slave. It drives that slave, or any AXI4-Lite responder, from control logic or a test sequencer on the same clock. Only one transaction is outstanding at a time.

## Interface
Parameters:
- ADDR_W, 32, width of cmd_addr and the AXI address buses.
- PROT, 3'b000, constant driven on m_axi_awprot and m_axi_arprot.

Ports:
- aclk, in, 1, clock; all logic on the rising edge.
- areset, in, 1, reset; asynchronous, active-high.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, command accepted when high together with cmd_valid.
- cmd_write, in, 1, 1 = write, 0 = read.
- cmd_addr, in, ADDR_W, byte address.
- cmd_wdata, in, 32, write data.
- cmd_wstrb, in, 4, write byte strobes.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, response consumed.
- rsp_write, out, 1, echoes cmd_write of the completed command.
- rsp_rdata, out, 32, read data; 0 for writes.
- rsp_resp, out, 2, BRESP or RRESP as received.
- m_axi_awaddr / m_axi_awprot / m_axi_awvalid, out, ADDR_W/3/1; m_axi_awready, in, 1.
- m_axi_wdata / m_axi_wstrb / m_axi_wvalid, out, 32/4/1; m_axi_wready, in, 1.
- m_axi_bresp, in, 2; m_axi_bvalid, in, 1; m_axi_bready, out, 1.
- m_axi_araddr / m_axi_arprot / m_axi_arvalid, out, ADDR_W/3/1; m_axi_arready, in, 1.
- m_axi_rdata, in, 32; m_axi_rresp, in, 2; m_axi_rvalid, in, 1; m_axi_rready, out, 1.

## Operation
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, RSP.
- cmd_ready = (state == IDLE) && !areset.
- **Command accept:** on a cmd handshake, register addr, wdata, wstrb and write into command registers. These drive the AXI address and data buses, which stay stable until the next accept.
- **WRITE:**
  - m_axi_awvalid and m_axi_wvalid are both asserted on entry.
  - Each valid drops on its own handshake; flags aw_done and w_done record completion.
  - AW and W may complete in either order or in the same cycle.
  - Exit to WRESP in the cycle after both flags are set, or directly when the last pending handshake occurs.
- **WRESP:** m_axi_bready = 1. On a B handshake, capture bresp into rsp_resp, set rsp_rdata = 0 and rsp_write = 1, then go to RSP.
- **READ:** m_axi_arvalid = 1 until the AR handshake, then go to RDATA.
- **RDATA:** m_axi_rready = 1. On an R handshake, capture rdata and rresp, set rsp_write = 0, then go to RSP.
- **RSP:** rsp_valid = 1. On the rsp_valid && rsp_ready edge, go to IDLE.
- **AXI rules:**
  - Once asserted, no VALID drops before its handshake.
  - Address, data and strobe are stable while VALID is high.
  - VALID never depends combinationally on READY.
- **Response codes:** SLVERR (2'b10) and DECERR (2'b11) are forwarded unchanged. No retry.
- Unexpected m_axi_bvalid or m_axi_rvalid outside WRESP/RDATA is ignored; its ready stays 0.

## Timing
- All AXI VALID/READY outputs and rsp_* outputs are registered.
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - All m_axi_*valid, m_axi_bready, m_axi_rready, rsp_valid = 0.
  - rsp_rdata, rsp_resp, rsp_write, addr/data/strb outputs = 0.
  - cmd_ready = 0 while areset is high and 1 in the first cycle after release.
- Cycle numbering: cycle 0 = cmd handshake.
- **Write, zero-wait slave:**
  - awvalid/wvalid high in cycle 1 and handshake there.
  - bready high from cycle 2.
  - If bvalid is present in cycle 2, rsp_valid is high in cycle 3.
  - cmd_ready returns in the cycle after the rsp handshake.
- **Read, zero-wait slave:** arvalid in cycle 1, rready from cycle 2, rsp_valid in cycle 3.
- Slave wait states add cycles 1:1 per stalled handshake.
- With rsp_ready held high, the minimum command-to-command spacing is 4 cycles.
- **Reset mid-transaction:** the transaction is abandoned, outputs return to reset values at once, and the next command starts clean.

## Test plan
- **Single write, always-ready slave:**
  - Stimulus: cmd write addr 0x4, data 0xDEADBEEF, strb 0xF.
  - Response: AW/W in cycle 1 with awaddr 0x4; rsp_valid in cycle 3 with rsp_resp 00 and rsp_write 1.
  - Check: a readback of 0x4 returns 0xDEADBEEF.
- **Split AW/W:**
  - Stimulus: wready high 3 cycles before awready.
  - Response: wvalid drops after the W handshake; awvalid stays high with stable awaddr; exactly one B accepted; one rsp.
- **Read with wait states and error:**
  - Stimulus: arready after 2 cycles; rvalid with rdata 0x12345678 and rresp 2'b10.
  - Response: rsp_rdata 0x12345678, rsp_resp 2'b10, rsp_write 0.
- **Response backpressure:**
  - Stimulus: rsp_ready low for 5 cycles.
  - Response: rsp_valid and data held stable; cmd_ready stays 0; no new AXI activity.
- **Back-to-back:**
  - Stimulus: write 0x8 = 0xA5A5A5A5, then read 0x8, with cmd_valid held high.
  - Response: responses in order; the read returns 0xA5A5A5A5.
- **Reset mid-write:**
  - Stimulus: assert areset while awvalid is high and awready is low.
  - Response: all valids are 0 in the same cycle; after release, cmd_ready = 1 and a new read completes normally.
